// File: rtl/wave_analyzer.sv
// wave_analyzer: measures peak, trough, amplitude and period of a sampled
// periodic waveform, tracking slope direction and period stability.
module wave_analyzer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        sample_valid,
  input  logic [7:0]  sample,
  output logic [7:0]  peak,
  output logic [7:0]  trough,
  output logic [7:0]  amplitude,
  output logic [15:0] period,
  output logic        meas_valid,
  output logic        slope_up,
  output logic        locked
);

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    RISING,
    FALLING
  } state_t;

  localparam logic [15:0] SAT = 16'hFFFF;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  prev;
  logic [7:0]  peak_cand;
  logic [7:0]  trough_cand;
  logic [15:0] cnt;
  logic        armed;

  logic        up;
  logic        dn;
  logic        peak_ev;
  logic        trough_ev;
  logic [15:0] cnt_inc;
  logic [7:0]  amp_nx;
  logic        lock_nx;

  assign up        = sample > prev;
  assign dn        = sample < prev;
  assign peak_ev   = (state == RISING) && dn;
  assign trough_ev = (state == FALLING) && up;

  // Counter value after one more accepted sample; doubles as the new
  // period on a trough event since it equals min(cnt+1, 16'hFFFF).
  assign cnt_inc = (cnt == SAT) ? cnt : cnt + 16'd1;

  // The trough being reported is prev, captured on this same edge.
  assign amp_nx = (peak_cand >= prev) ? peak_cand - prev : 8'd0;

  assign lock_nx = (cnt_inc == period) && (cnt_inc != SAT)
                   && (period != SAT);

  // Next direction state for an accepted sample.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = FIRST;
      FIRST: begin
        if (up)      state_nx = RISING;
        else if (dn) state_nx = FALLING;
      end
      RISING:  if (dn) state_nx = FALLING;
      FALLING: if (up) state_nx = RISING;
      default: state_nx = IDLE;
    endcase
  end

  // Sample acceptance, extremum capture, period counting, reported outputs.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state       <= IDLE;
      prev        <= 8'd0;
      peak_cand   <= 8'd0;
      trough_cand <= 8'd0;
      cnt         <= 16'd0;
      armed       <= 1'b0;
      peak        <= 8'd0;
      trough      <= 8'd0;
      amplitude   <= 8'd0;
      period      <= 16'd0;
      meas_valid  <= 1'b0;
      slope_up    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (sample_valid) begin
        prev     <= sample;
        state    <= state_nx;
        slope_up <= (state_nx == RISING);
        if (peak_ev) begin
          peak_cand <= prev;
        end
        if (trough_ev) begin
          trough_cand <= prev;
          cnt         <= 16'd0;
          if (armed) begin
            period     <= cnt_inc;
            peak       <= peak_cand;
            trough     <= prev;
            amplitude  <= amp_nx;
            locked     <= lock_nx;
            meas_valid <= 1'b1;
          end else begin
            armed <= 1'b1;
          end
        end else begin
          cnt <= cnt_inc;
          if (cnt_inc == SAT) begin
            locked <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wave_analyzer.sv
// tb_wave_analyzer: directed scenarios plus random stimulus, checked every
// cycle against a direction-tracking reference model.
module tb_wave_analyzer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        sample_valid;
  logic [7:0]  sample;
  logic [7:0]  peak;
  logic [7:0]  trough;
  logic [7:0]  amplitude;
  logic [15:0] period;
  logic        meas_valid;
  logic        slope_up;
  logic        locked;

  int checks = 0;
  int errors = 0;
  bit go = 0;

  always #5 clk = ~clk;

  wave_analyzer dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .sample_valid(sample_valid),
    .sample(sample),
    .peak(peak),
    .trough(trough),
    .amplitude(amplitude),
    .period(period),
    .meas_valid(meas_valid),
    .slope_up(slope_up),
    .locked(locked)
  );

  // Reference model: dir is the sign of the last non-zero sample delta.
  bit started, armed;
  int dir, prv, pk, tr, cnt;
  int m_peak, m_trough, m_amp, m_period;
  bit m_mv, m_slope, m_locked;

  task automatic model_step(bit r, bit c, bit v, int s);
    bit tev;
    int np;
    m_mv = 0;
    if (r || c) begin
      started = 0; armed = 0; dir = 0; prv = 0; pk = 0; tr = 0; cnt = 0;
      m_peak = 0; m_trough = 0; m_amp = 0; m_period = 0;
      m_slope = 0; m_locked = 0;
      return;
    end
    if (!v) return;
    tev = 0;
    if (!started) begin
      started = 1;
      dir = 0;
    end else if (s > prv) begin
      if (dir < 0) begin
        tr = prv;
        tev = 1;
      end
      dir = 1;
    end else if (s < prv) begin
      if (dir > 0) pk = prv;
      dir = -1;
    end
    prv = s;
    if (tev) begin
      if (armed) begin
        np = (cnt + 1 > 65535) ? 65535 : cnt + 1;
        m_locked = (np == m_period) && (np != 65535);
        m_period = np;
        m_peak = pk;
        m_trough = tr;
        m_amp = (pk > tr) ? pk - tr : 0;
        m_mv = 1;
      end else begin
        armed = 1;
      end
      cnt = 0;
    end else begin
      if (cnt < 65535) cnt++;
      if (cnt == 65535) m_locked = 0;
    end
    m_slope = (dir > 0);
  endtask

  // Every-cycle comparison of the full output bundle against the model.
  always @(negedge clk) begin
    if (go) begin
      checks++;
      if (peak !== 8'(m_peak) || trough !== 8'(m_trough) ||
          amplitude !== 8'(m_amp) || period !== 16'(m_period) ||
          meas_valid !== m_mv || slope_up !== m_slope ||
          locked !== m_locked) begin
        errors++;
        $display("FAIL model t=%0t got pk=%0d tr=%0d amp=%0d per=%0d mv=%0b up=%0b lk=%0b want pk=%0d tr=%0d amp=%0d per=%0d mv=%0b up=%0b lk=%0b",
                 $time, peak, trough, amplitude, period, meas_valid,
                 slope_up, locked, m_peak, m_trough, m_amp, m_period,
                 m_mv, m_slope, m_locked);
      end
    end
  end

  int npulse = 0;
  int cyc = 0;
  int lastp = 0;
  int gap = 0;

  task automatic step(bit r, bit c, bit v, int s);
    rst = r; clear = c; sample_valid = v; sample = 8'(s);
    @(posedge clk);
    model_step(r, c, v, s);
    #1;
    go = 1;
    cyc++;
    if (meas_valid) begin
      npulse++;
      gap = cyc - lastp;
      lastp = cyc;
    end
  endtask

  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, a, e);
    end
  endtask

  task automatic chk_zero(string n);
    chk({n, "_pk"}, peak, 0);
    chk({n, "_tr"}, trough, 0);
    chk({n, "_amp"}, amplitude, 0);
    chk({n, "_per"}, period, 0);
    chk({n, "_mv"}, meas_valid, 0);
    chk({n, "_up"}, slope_up, 0);
    chk({n, "_lk"}, locked, 0);
  endtask

  int tri8[8] = '{0, 1, 2, 3, 4, 3, 2, 1};
  int seq4[4] = '{2, 1, 0, 1};
  int plat[8] = '{0, 1, 2, 2, 2, 1, 0, 0};
  int p0;
  int rs;

  initial begin
    rst = 1; clear = 0; sample_valid = 0; sample = 0;
    step(1, 0, 0, 0);
    step(1, 0, 1, 9);
    chk_zero("reset");

    npulse = 0;
    for (int i = 0; i < 26; i++) begin
      step(0, 0, 1, tri8[i % 8]);
      if (i == 16) chk("tri_nopulse_before17", npulse, 0);
      if (i == 17) begin
        chk("tri17_mv", meas_valid, 1);
        chk("tri17_per", period, 8);
        chk("tri17_pk", peak, 4);
        chk("tri17_tr", trough, 0);
        chk("tri17_amp", amplitude, 4);
        chk("tri17_lk", locked, 0);
      end
      if (i == 25) begin
        chk("tri25_mv", meas_valid, 1);
        chk("tri25_lk", locked, 1);
      end
    end

    for (int j = 0; j < 12; j++) begin
      step(0, 0, 1, seq4[j % 4]);
      if (j == 3) begin
        chk("sw1_mv", meas_valid, 1);
        chk("sw1_per", period, 4);
        chk("sw1_amp", amplitude, 2);
        chk("sw1_lk", locked, 0);
      end
      if (j == 7) chk("sw2_lk", locked, 1);
    end

    chk("pre_const_lk", locked, 1);
    p0 = npulse;
    for (int k = 0; k < 65540; k++) step(0, 0, 1, 1);
    chk("const_lk", locked, 0);
    chk("const_nopulse", npulse - p0, 0);

    for (int i = 0; i < 12; i++) step(0, 0, 1, tri8[i % 8]);
    step(1, 0, 1, 3);
    chk_zero("midrst");
    npulse = 0;
    for (int i = 0; i < 18; i++) begin
      step(0, 0, 1, tri8[i % 8]);
      if (i == 16) chk("midrst_nopulse", npulse, 0);
    end
    chk("midrst_first_pulse", npulse, 1);

    step(0, 1, 0, 0);
    for (int i = 0; i < 18; i++) begin
      step(0, 0, 1, plat[i % 8]);
      if (i >= 2 && i <= 4) chk("plat_up", slope_up, 1);
      if (i == 17) begin
        chk("plat_mv", meas_valid, 1);
        chk("plat_per", period, 8);
        chk("plat_pk", peak, 2);
        chk("plat_tr", trough, 0);
      end
    end

    step(1, 0, 0, 0);
    for (int i = 0; i < 26; i++) begin
      step(0, 0, 1, tri8[i % 8]);
      step(0, 0, 0, $urandom_range(0, 255));
    end
    chk("half_gap", gap, 16);
    chk("half_per", period, 8);
    chk("half_amp", amplitude, 4);
    chk("half_lk", locked, 1);

    for (int i = 0; i < 5; i++) step(0, 0, 1, tri8[i % 8]);
    step(0, 1, 1, 200);
    chk_zero("clear");

    rs = 128;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rs = $urandom_range(0, 255);
      else rs = (rs + $urandom_range(0, 6) + 253) & 255;
      step($urandom_range(0, 499) == 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 3) != 0, rs);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
